// File: rtl/eth_pkg.sv
// Shared Ethernet transmit definitions: ethertypes, frame size defaults,
// framer state encoding and header byte selection.
package eth_pkg;

    localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
    localparam logic [15:0] ETH_TYPE_IP   = 16'h0800;
    localparam logic [15:0] ETH_TYPE_RARP = 16'h8035;

    localparam int MIN_FRAME_DEFAULT = 60;
    localparam int MAX_FRAME_DEFAULT = 1514;
    localparam int HDR_LEN           = 14;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_PAD,
        ST_DRAIN
    } tx_state_t;

    // Header is dst MAC, src MAC, ethertype, sent MSB byte first.
    function automatic logic [7:0] hdrByte(
        input logic [47:0] dstMac,
        input logic [47:0] srcMac,
        input logic [15:0] etherType,
        input logic [3:0]  idx
    );
        logic [111:0] hdr;
        logic [111:0] shifted;
        hdr     = {dstMac, srcMac, etherType};
        shifted = hdr << {idx, 3'b000};
        return shifted[111:104];
    endfunction

endpackage

// File: rtl/tx_arbiter.sv
// Two-way round-robin grant between the ARP (bit 0) and IP (bit 1) sources;
// the last-grant memory only moves when a frame actually starts.
module tx_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output logic [1:0] o_grant
);

    logic r_lastIp;

    always_comb begin
        o_grant = i_req;
        if (i_req == 2'b11) begin
            o_grant = r_lastIp ? 2'b01 : 2'b10;
        end
    end

    // Starting from "IP last" lets ARP win the first tie after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lastIp <= 1'b1;
        end else if (i_update && (|o_grant)) begin
            r_lastIp <= o_grant[1];
        end
    end

endmodule

// File: rtl/eth_tx_framer.sv
// Ethernet transmit framer: arbitrates ARP/IP payload streams, prepends the
// 14-byte MAC header, pads short frames and truncates oversized ones.
module eth_tx_framer
    import eth_pkg::*;
#(
    parameter int MIN_FRAME = MIN_FRAME_DEFAULT,
    parameter int MAX_FRAME = MAX_FRAME_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [47:0] mac_addr,
    input  logic [47:0] arp_dst_mac_in,
    input  logic [47:0] ip_dst_mac_in,
    input  logic [7:0]  arp_axis_tdata_in,
    input  logic        arp_axis_tvalid_in,
    input  logic        arp_axis_tlast_in,
    output logic        arp_axis_tready_o,
    input  logic [7:0]  ip_axis_tdata_in,
    input  logic        ip_axis_tvalid_in,
    input  logic        ip_axis_tlast_in,
    output logic        ip_axis_tready_o,
    output logic [7:0]  axis_tdata_out,
    output logic        axis_tvalid_out,
    output logic        axis_tlast_out,
    input  logic        axis_tready_in,
    output logic        truncated_o
);

    localparam logic [10:0] HDR_LAST = 11'(HDR_LEN - 1);
    localparam logic [10:0] MIN_LAST = 11'(MIN_FRAME - 1);
    localparam logic [10:0] MAX_LAST = 11'(MAX_FRAME - 1);

    tx_state_t   r_state;
    tx_state_t   w_stateNext;
    logic [10:0] r_cnt;
    logic [10:0] w_cntNext;
    logic        r_srcIp;
    logic [47:0] r_dstMac;
    logic [15:0] r_etherType;

    logic [1:0]  w_req;
    logic [1:0]  w_grant;
    logic        w_start;
    logic        w_srcReady;
    logic [7:0]  w_srcData;
    logic        w_srcValid;
    logic        w_srcLast;

    assign w_req      = {ip_axis_tvalid_in, arp_axis_tvalid_in};
    assign w_srcData  = r_srcIp ? ip_axis_tdata_in  : arp_axis_tdata_in;
    assign w_srcValid = r_srcIp ? ip_axis_tvalid_in : arp_axis_tvalid_in;
    assign w_srcLast  = r_srcIp ? ip_axis_tlast_in  : arp_axis_tlast_in;

    assign arp_axis_tready_o = w_srcReady & ~r_srcIp;
    assign ip_axis_tready_o  = w_srcReady &  r_srcIp;

    tx_arbiter u_arbiter (
        .clk      (clk),
        .reset    (reset),
        .i_req    (w_req),
        .i_update (w_start),
        .o_grant  (w_grant)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_srcIp     <= 1'b0;
            r_dstMac    <= '0;
            r_etherType <= '0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            if (w_start) begin
                r_srcIp     <= w_grant[1];
                r_dstMac    <= w_grant[1] ? ip_dst_mac_in : arp_dst_mac_in;
                r_etherType <= w_grant[1] ? ETH_TYPE_IP : ETH_TYPE_ARP;
            end
        end
    end

    // The counter holds the byte index within the outgoing frame (header included).
    always_comb begin
        w_stateNext     = r_state;
        w_cntNext       = r_cnt;
        w_start         = 1'b0;
        w_srcReady      = 1'b0;
        axis_tdata_out  = 8'h00;
        axis_tvalid_out = 1'b0;
        axis_tlast_out  = 1'b0;
        truncated_o     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (|w_req) begin
                    w_start     = 1'b1;
                    w_cntNext   = '0;
                    w_stateNext = ST_HDR;
                end
            end

            ST_HDR: begin
                axis_tvalid_out = 1'b1;
                axis_tdata_out  = hdrByte(r_dstMac, mac_addr, r_etherType, r_cnt[3:0]);
                if (axis_tready_in) begin
                    w_cntNext = r_cnt + 11'd1;
                    if (r_cnt == HDR_LAST) begin
                        w_stateNext = ST_PAYLOAD;
                    end
                end
            end

            ST_PAYLOAD: begin
                axis_tvalid_out = w_srcValid;
                axis_tdata_out  = w_srcData;
                w_srcReady      = axis_tready_in;
                axis_tlast_out  = w_srcValid &&
                                  (w_srcLast ? (r_cnt >= MIN_LAST) : (r_cnt == MAX_LAST));
                if (w_srcValid && axis_tready_in) begin
                    w_cntNext = r_cnt + 11'd1;
                    if (w_srcLast) begin
                        w_stateNext = (r_cnt >= MIN_LAST) ? ST_IDLE : ST_PAD;
                    end else if (r_cnt == MAX_LAST) begin
                        truncated_o = 1'b1;
                        w_stateNext = ST_DRAIN;
                    end
                end
            end

            ST_PAD: begin
                axis_tvalid_out = 1'b1;
                axis_tlast_out  = (r_cnt == MIN_LAST);
                if (axis_tready_in) begin
                    w_cntNext = r_cnt + 11'd1;
                    if (r_cnt == MIN_LAST) begin
                        w_stateNext = ST_IDLE;
                    end
                end
            end

            // Swallow the rest of an oversized payload so the source sees its tlast accepted.
            ST_DRAIN: begin
                w_srcReady = 1'b1;
                if (w_srcValid && w_srcLast) begin
                    w_stateNext = ST_IDLE;
                end
            end

            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Scoreboard bench for eth_tx_framer: each scenario queues the frame it expects
// and a negedge monitor pops and compares every byte the framer emits.
`timescale 1ns/1ps
module tb_eth_tx_framer;

    localparam int          MIN_F     = 60;
    localparam int          MAX_F     = 1514;
    localparam logic [47:0] LOCAL_MAC = 48'h02_11_22_33_44_55;
    localparam logic [47:0] BCAST     = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] IP_DST    = 48'h00_1A_2B_3C_4D_5E;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [47:0] arp_dst_mac_in = BCAST;
    logic [47:0] ip_dst_mac_in = IP_DST;
    logic [7:0]  arp_axis_tdata_in = 8'h00;
    logic        arp_axis_tvalid_in = 1'b0;
    logic        arp_axis_tlast_in = 1'b0;
    logic        arp_axis_tready_o;
    logic [7:0]  ip_axis_tdata_in = 8'h00;
    logic        ip_axis_tvalid_in = 1'b0;
    logic        ip_axis_tlast_in = 1'b0;
    logic        ip_axis_tready_o;
    logic [7:0]  axis_tdata_out;
    logic        axis_tvalid_out;
    logic        axis_tlast_out;
    logic        axis_tready_in = 1'b1;
    logic        truncated_o;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t expQ[$];
    exp_t popped;
    int   assertCount = 0;
    int   failCount = 0;
    bit   monEnable = 1'b0;
    bit   randReady = 1'b0;
    bit   readyLevel = 1'b1;
    int   rxIndex = 0;
    int   truncPulses = 0;
    int   truncIndex = -1;
    int   stallCount = 0;
    logic prevValid = 1'b0;
    logic prevReady = 1'b0;
    logic [7:0] prevData = 8'h00;
    logic prevLast = 1'b0;

    eth_tx_framer dut (
        .clk                (clk),
        .reset              (reset),
        .mac_addr           (LOCAL_MAC),
        .arp_dst_mac_in     (arp_dst_mac_in),
        .ip_dst_mac_in      (ip_dst_mac_in),
        .arp_axis_tdata_in  (arp_axis_tdata_in),
        .arp_axis_tvalid_in (arp_axis_tvalid_in),
        .arp_axis_tlast_in  (arp_axis_tlast_in),
        .arp_axis_tready_o  (arp_axis_tready_o),
        .ip_axis_tdata_in   (ip_axis_tdata_in),
        .ip_axis_tvalid_in  (ip_axis_tvalid_in),
        .ip_axis_tlast_in   (ip_axis_tlast_in),
        .ip_axis_tready_o   (ip_axis_tready_o),
        .axis_tdata_out     (axis_tdata_out),
        .axis_tvalid_out    (axis_tvalid_out),
        .axis_tlast_out     (axis_tlast_out),
        .axis_tready_in     (axis_tready_in),
        .truncated_o        (truncated_o)
    );

    always #5 clk = ~clk;

    // All inputs change 1ns after the rising edge; all sampling happens on the falling edge.
    always @(posedge clk) begin
        #1;
        axis_tready_in = randReady ? 1'($urandom_range(0, 1)) : readyLevel;
    end

    always @(negedge clk) begin
        if (monEnable && !reset) begin
            if (prevValid && !prevReady) begin
                stallCount++;
                assertCount++;
                if (axis_tvalid_out !== 1'b1 || axis_tdata_out !== prevData || axis_tlast_out !== prevLast) begin
                    failCount++;
                    $display("[TB] FAIL stall_hold: got valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                             axis_tvalid_out, axis_tdata_out, axis_tlast_out, prevData, prevLast);
                end
            end
            if (truncated_o === 1'b1) begin
                truncPulses++;
                truncIndex = rxIndex;
                assertCount++;
                if (!(axis_tvalid_out && axis_tready_in && axis_tlast_out)) begin
                    failCount++;
                    $display("[TB] FAIL trunc_with_last: got valid=%b ready=%b last=%b, required all 1",
                             axis_tvalid_out, axis_tready_in, axis_tlast_out);
                end
            end
            if (axis_tvalid_out && axis_tready_in) begin
                assertCount++;
                if (expQ.size() == 0) begin
                    failCount++;
                    $display("[TB] FAIL unexpected_byte: got data=%h last=%b, required no output", axis_tdata_out, axis_tlast_out);
                end else begin
                    popped = expQ.pop_front();
                    if ({axis_tdata_out, axis_tlast_out} !== popped) begin
                        failCount++;
                        $display("[TB] FAIL frame_byte[%0d]: got data=%h last=%b, required data=%h last=%b",
                                 rxIndex, axis_tdata_out, axis_tlast_out, popped.data, popped.last);
                    end
                end
                rxIndex = axis_tlast_out ? 0 : rxIndex + 1;
            end
            prevValid = axis_tvalid_out;
            prevReady = axis_tready_in;
            prevData  = axis_tdata_out;
            prevLast  = axis_tlast_out;
        end else begin
            prevValid = 1'b0;
            rxIndex   = 0;
        end
    end

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic setSource(input bit isIp, input logic v, input logic [7:0] d, input logic l);
        if (isIp) begin
            ip_axis_tvalid_in = v;
            ip_axis_tdata_in  = d;
            ip_axis_tlast_in  = l;
        end else begin
            arp_axis_tvalid_in = v;
            arp_axis_tdata_in  = d;
            arp_axis_tlast_in  = l;
        end
    endtask

    task automatic driveSource(input bit isIp, input int len, input logic [7:0] seed);
        bit hs;
        int waitCycles;
        for (int k = 0; k < len; k++) begin
            setSource(isIp, 1'b1, seed + 8'(k), (k == len - 1));
            waitCycles = 0;
            do begin
                @(negedge clk);
                hs = isIp ? ip_axis_tready_o : arp_axis_tready_o;
                @(posedge clk);
                #1;
                waitCycles++;
            end while (!hs && waitCycles < 4000);
            if (!hs) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL src_timeout: source %0d byte %0d not accepted, required acceptance", isIp, k);
                setSource(isIp, 1'b0, 8'h00, 1'b0);
                return;
            end
        end
        setSource(isIp, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic expectFrame(input logic [47:0] dst, input logic [15:0] etype, input int len, input logic [7:0] seed);
        int outLen;
        logic [111:0] hdr;
        exp_t e;
        hdr    = {dst, LOCAL_MAC, etype};
        outLen = 14 + len;
        if (outLen > MAX_F) outLen = MAX_F;
        if (outLen < MIN_F) outLen = MIN_F;
        for (int i = 0; i < outLen; i++) begin
            if (i < 14) e.data = hdr[111 - 8 * i -: 8];
            else if (i - 14 < len) e.data = seed + 8'(i - 14);
            else e.data = 8'h00;
            e.last = (i == outLen - 1);
            expQ.push_back(e);
        end
    endtask

    task automatic waitDrain(output int left);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        left = expQ.size();
        expQ.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        monEnable = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        monEnable = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        assertCount++;
        if ({axis_tvalid_out, axis_tlast_out, axis_tdata_out} !== 10'd0) begin
            failCount++;
            $display("[TB] FAIL reset_out: got valid=%b last=%b data=%h, required 0 0 00", axis_tvalid_out, axis_tlast_out, axis_tdata_out);
        end
        assertCount++;
        if ({arp_axis_tready_o, ip_axis_tready_o, truncated_o} !== 3'b000) begin
            failCount++;
            $display("[TB] FAIL reset_ready: got arp=%b ip=%b trunc=%b, required 0 0 0", arp_axis_tready_o, ip_axis_tready_o, truncated_o);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        monEnable = 1'b1;
    endtask

    task automatic test_arp_pad();
        int left;
        expectFrame(BCAST, 16'h0806, 28, 8'h10);
        driveSource(1'b0, 28, 8'h10);
        waitDrain(left);
        assertCount++;
        if (left != 0) begin
            failCount++;
            $display("[TB] FAIL arp_pad_complete: got %0d bytes outstanding, required 0", left);
        end
        expectFrame(BCAST, 16'h0806, 1, 8'hA0);
        driveSource(1'b0, 1, 8'hA0);
        waitDrain(left);
        assertCount++;
        if (left != 0) begin
            failCount++;
            $display("[TB] FAIL one_byte_complete: got %0d bytes outstanding, required 0", left);
        end
    endtask

    task automatic test_ip_full();
        int left;
        truncPulses = 0;
        expectFrame(IP_DST, 16'h0800, 100, 8'h33);
        driveSource(1'b1, 100, 8'h33);
        waitDrain(left);
        assertCount++;
        if (left != 0) begin
            failCount++;
            $display("[TB] FAIL ip_full_complete: got %0d bytes outstanding, required 0", left);
        end
        assertCount++;
        if (truncPulses != 0) begin
            failCount++;
            $display("[TB] FAIL ip_no_trunc: got %0d pulses, required 0", truncPulses);
        end
    endtask

    task automatic test_back_to_back();
        int left;
        applyReset();
        for (int round = 0; round < 2; round++) begin
            expectFrame(BCAST, 16'h0806, 20, 8'h40 + 8'(round));
            expectFrame(IP_DST, 16'h0800, 50, 8'h80 + 8'(round));
            fork
                driveSource(1'b0, 20, 8'h40 + 8'(round));
                driveSource(1'b1, 50, 8'h80 + 8'(round));
            join
            waitDrain(left);
            assertCount++;
            if (left != 0) begin
                failCount++;
                $display("[TB] FAIL tie_round%0d_complete: got %0d bytes outstanding, required 0", round, left);
            end
        end
    endtask

    task automatic test_truncate();
        int left;
        truncPulses = 0;
        truncIndex  = -1;
        expectFrame(IP_DST, 16'h0800, 1600, 8'h07);
        driveSource(1'b1, 1600, 8'h07);
        waitDrain(left);
        assertCount++;
        if (left != 0) begin
            failCount++;
            $display("[TB] FAIL trunc_complete: got %0d bytes outstanding, required 0", left);
        end
        assertCount++;
        if (truncPulses != 1 || truncIndex != MAX_F - 1) begin
            failCount++;
            $display("[TB] FAIL trunc_pulse: got %0d pulses at byte %0d, required 1 at byte %0d", truncPulses, truncIndex, MAX_F - 1);
        end
        @(negedge clk);
        assertCount++;
        if ({axis_tvalid_out, ip_axis_tready_o, arp_axis_tready_o} !== 3'b000) begin
            failCount++;
            $display("[TB] FAIL trunc_idle: got valid=%b ip_ready=%b arp_ready=%b, required 0 0 0",
                     axis_tvalid_out, ip_axis_tready_o, arp_axis_tready_o);
        end
    endtask

    task automatic test_backpressure();
        int left;
        stallCount = 0;
        randReady  = 1'b1;
        expectFrame(IP_DST, 16'h0800, 46, 8'hC5);
        driveSource(1'b1, 46, 8'hC5);
        waitDrain(left);
        randReady = 1'b0;
        readyLevel = 1'b1;
        assertCount++;
        if (left != 0) begin
            failCount++;
            $display("[TB] FAIL bp_complete: got %0d bytes outstanding, required 0", left);
        end
        assertCount++;
        if (stallCount == 0) begin
            failCount++;
            $display("[TB] FAIL bp_stalls: got %0d stalled cycles, required at least 1", stallCount);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midframe();
        int left;
        int idx;
        int n;
        monEnable = 1'b0;
        setSource(1'b0, 1'b1, 8'h5A, 1'b0);
        idx = 0;
        n = 0;
        while (idx < 8 && n < 100) begin
            @(negedge clk);
            if (axis_tvalid_out && axis_tready_in) idx++;
            n++;
        end
        @(negedge clk);
        assertCount++;
        if (idx != 8 || axis_tdata_out !== LOCAL_MAC[31:24] || axis_tvalid_out !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL mid_hdr_byte8: got count=%0d valid=%b data=%h, required 8 1 %h", idx, axis_tvalid_out, axis_tdata_out, LOCAL_MAC[31:24]);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        assertCount++;
        if ({axis_tvalid_out, axis_tlast_out, axis_tdata_out, arp_axis_tready_o, ip_axis_tready_o} !== 12'd0) begin
            failCount++;
            $display("[TB] FAIL mid_reset_out: got valid=%b last=%b data=%h arp_ready=%b ip_ready=%b, required all 0",
                     axis_tvalid_out, axis_tlast_out, axis_tdata_out, arp_axis_tready_o, ip_axis_tready_o);
        end
        setSource(1'b0, 1'b0, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        monEnable = 1'b1;
        expectFrame(BCAST, 16'h0806, 28, 8'h61);
        driveSource(1'b0, 28, 8'h61);
        waitDrain(left);
        assertCount++;
        if (left != 0) begin
            failCount++;
            $display("[TB] FAIL post_reset_complete: got %0d bytes outstanding, required 0", left);
        end
    endtask

    initial begin
        test_reset();
        test_arp_pad();
        test_ip_full();
        test_back_to_back();
        test_truncate();
        test_backpressure();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/eth_tx_framer.md
ETH_TX_FRAMER -- requirements
Module: eth_tx_framer

Interface
REQ-001 SHALL have parameter MIN_FRAME, default 60, minimum frame bytes excluding FCS.
REQ-002 SHALL have parameter MAX_FRAME, default 1514, maximum frame bytes excluding FCS.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 mac_addr  input  48  local MAC, used as source address.
REQ-006 arp_dst_mac_in  input  48  destination MAC for the ARP frame; sampled at grant.
REQ-007 ip_dst_mac_in  input  48  destination MAC for the IP frame; sampled at grant.
REQ-008 arp_axis_tdata_in / tvalid_in / tlast_in  input  8/1/1  ARP payload byte stream.
REQ-009 arp_axis_tready_o  output  1  ARP source accept.
REQ-010 ip_axis_tdata_in / tvalid_in / tlast_in  input  8/1/1  IP payload byte stream.
REQ-011 ip_axis_tready_o  output  1  IP source accept.
REQ-012 axis_tdata_out / tvalid_out / tlast_out  output  8/1/1  framed Ethernet byte stream to MAC.
REQ-013 axis_tready_in  input  1  MAC accept.
REQ-014 truncated_o  output  1  one-cycle pulse when a frame was cut at MAX_FRAME.

Function
REQ-015 A byte transfers on any port only when tvalid and tready are both 1 in the same cycle.
REQ-016 States SHALL be IDLE, HDR, PAYLOAD, PAD, DRAIN; state and byte counter (11 bits) registered; output data/valid/last combinational from state, counter and granted source.
REQ-017 IDLE: tvalid_out=0, both tready_o=0; when any source tvalid_in=1, grant one, latch its dst MAC and ethertype (ARP 0x0806, IP 0x0800), clear counter, go HDR next cycle.
REQ-018 Arbitration: only one requester -> grant it; both -> grant the source not granted last (last-grant register resets to IP, so ARP wins first tie).
REQ-019 HDR: tvalid_out=1; byte index 0-5 dst MAC, 6-11 mac_addr, 12-13 ethertype, each MSB byte first; counter increments per output transfer; after index 13 transfers go PAYLOAD.
REQ-020 PAYLOAD: tdata_out=granted tdata_in, tvalid_out=granted tvalid_in, granted tready_o=axis_tready_in, other tready_o=0; zero added latency.
REQ-021 PAYLOAD tlast: source tlast at index >= MIN_FRAME-1 -> tlast_out=1, go IDLE; at index < MIN_FRAME-1 -> tlast_out=0, go PAD.
REQ-022 PAD: tvalid_out=1, tdata_out=0x00, both tready_o=0; tlast_out=1 at index MIN_FRAME-1, then IDLE.
REQ-023 Oversize: at index MAX_FRAME-1 without source tlast -> tlast_out=1, pulse truncated_o on that transfer, go DRAIN.
REQ-024 DRAIN: tvalid_out=0, granted tready_o=1; discard bytes until source tlast accepted, then IDLE.
REQ-025 Output SHALL hold tdata/tlast stable while tvalid_out=1 and axis_tready_in=0.
REQ-026 A source asserting tvalid_in mid-frame of the other SHALL wait; no interleaving; one IDLE cycle minimum between frames.
REQ-027 Source tlast on first payload byte SHALL be legal (1-byte payload, padded).

Reset
REQ-028 On reset: state IDLE, counter 0, last-grant IP, tvalid_out=0, tlast_out=0, tdata_out=0, both tready_o=0, truncated_o=0.
REQ-029 Reset mid-frame SHALL abandon the frame without tlast; next frame after reset starts at header index 0.

Structure
REQ-030 Shared package eth_pkg SHALL hold ethertype constants (ARP 0x0806, IP 0x0800, RARP 0x8035), MIN_FRAME/MAX_FRAME defaults and state encoding.
REQ-031 2-way round-robin grant SHALL be sub-module tx_arbiter (req[1:0], grant one-hot, update on frame start).

Verification
REQ-032 ARP only, dst FF:FF:FF:FF:FF:FF, 28-byte payload, tready_in=1 -> 60 bytes out, type 08 06, bytes 42-59 = 0x00, tlast on byte 59.
REQ-033 IP 100-byte payload -> 114 bytes, type 08 00, no pad, tlast on byte 113 coincident with source tlast.
REQ-034 ARP and IP tvalid same cycle from reset -> ARP frame first, IP frame next; repeat tie -> ARP first again (alternation).
REQ-035 IP 1600-byte payload -> 1514 bytes, tlast on byte 1513, truncated_o one pulse, remaining 100 source bytes drained, then IDLE.
REQ-036 Random tready_in backpressure (50%) on 46-byte IP frame -> byte sequence identical to unstalled case, data stable while stalled.
REQ-037 Reset asserted at header byte 8 -> outputs zero next cycle; following ARP frame complete from byte 0.
